// File: rtl/uart_pkg.sv
// Shared definitions for the byte UART transmitter.
//   tx_state_e : frame FSM state encoding
//   PAR_*      : parity mode codes accepted by the PARITY parameter
//   clog2      : width helper for counters
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    // Bits needed to hold the values 0..v-1 (minimum 1).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 1) ? v - 1 : 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_byte_tx_if.sv
// Byte handshake between the formatting stage and the UART transmitter.
//   txStart : level request from upstream, sampled only while the UART is idle
//   txData  : byte to send, captured on acceptance
//   txBusy  : high while a frame is in progress
// master = upstream byte source, slave = uart_byte_tx.
interface uart_byte_tx_if;

    logic       txStart;
    logic [7:0] txData;
    logic       txBusy;

    modport master (
        output txStart,
        output txData,
        input  txBusy
    );

    modport slave (
        input  txStart,
        input  txData,
        output txBusy
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-time generator: counts 0..BAUD_DIV-1 while enabled and pulses tick_o
// for one cycle on the last count.
//   clk, uartTxRstN : clock, asynchronous active-low reset
//   clr_i           : restart the bit time from count 0 (frame acceptance)
//   en_i            : count enable; the counter sits at 0 while low
//   tick_o          : one-cycle bit-time end pulse
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 868
) (
    input  logic clk,
    input  logic uartTxRstN,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned CNT_W = clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !en_i) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge uartTxRstN) begin
        if (!uartTxRstN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && !clr_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_byte_tx.sv
// Byte-level 8N1/8x1/8x2 UART serializer driving the board TX pin.
// Frame: start bit, 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
//   clk, uartTxRstN : clock, asynchronous active-low reset
//   txIf (slave)    : txStart/txData request, txBusy status (registered)
//   tx              : serial line, idles high
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD_RATE = 115200,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic           clk,
    input  logic           uartTxRstN,
    uart_byte_tx_if.slave  txIf,
    output logic           tx
);

    localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam bit          HAS_PAR  = (PARITY == PAR_ODD) || (PARITY == PAR_EVEN);
    localparam bit          PAR_IS_ODD = (PARITY == PAR_ODD);
    localparam int unsigned NSTOP    = (STOP_BITS == 2) ? 2 : 1;
    localparam logic [2:0]  STOP_LAST = 3'(NSTOP - 1);

    tx_state_e  state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bitIdx_q, bitIdx_d;   // data bit index in DATA, stop bit index in STOP
    logic       parAcc_q, parAcc_d;   // running XOR of the bits already sent
    logic       busy_q;
    logic       baudClr;
    logic       baudTick;

    uart_baud_tick #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .clk        (clk),
        .uartTxRstN (uartTxRstN),
        .clr_i      (baudClr),
        .en_i       (busy_q),
        .tick_o     (baudTick)
    );

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitIdx_d = bitIdx_q;
        parAcc_d = parAcc_q;
        baudClr  = 1'b0;
        tx       = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                tx = 1'b1;
                if (txIf.txStart) begin
                    shreg_d  = txIf.txData;
                    bitIdx_d = '0;
                    parAcc_d = 1'b0;
                    baudClr  = 1'b1;
                    state_d  = ST_START;
                end
            end

            ST_START: begin
                tx = 1'b0;
                if (baudTick) begin
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                tx = shreg_q[0];
                if (baudTick) begin
                    shreg_d  = {1'b0, shreg_q[7:1]};
                    parAcc_d = parAcc_q ^ shreg_q[0];
                    if (bitIdx_q == 3'd7) begin
                        bitIdx_d = '0;
                        state_d  = HAS_PAR ? ST_PARITY : ST_STOP;
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end
            end

            ST_PARITY: begin
                tx = PAR_IS_ODD ? ~parAcc_q : parAcc_q;
                if (baudTick) begin
                    state_d = ST_STOP;
                end
            end

            ST_STOP: begin
                tx = 1'b1;
                if (baudTick) begin
                    if (bitIdx_q == STOP_LAST) begin
                        bitIdx_d = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge uartTxRstN) begin
        if (!uartTxRstN) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            bitIdx_q <= '0;
            parAcc_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitIdx_q <= bitIdx_d;
            parAcc_q <= parAcc_d;
            // Registered from the next state so it rises with the start bit
            // and falls on the first IDLE cycle.
            busy_q   <= (state_d != ST_IDLE);
        end
    end

    assign txIf.txBusy = busy_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Self-checking bench: four transmitters (none/1 stop, even, odd, none/2 stop)
// at BAUD_DIV = 10, checked cycle by cycle against an ideal frame model.
module tb_uart_byte_tx;

    localparam int unsigned DIV = 10;

    logic       clk;
    logic       rstN;
    logic [3:0] start_r;
    logic [7:0] data_r [4];
    logic [3:0] tx_w;
    logic [3:0] busy_w;

    int checks;
    int errors;

    function automatic int unsigned par_of(input int unsigned idx);
        return (idx == 1) ? 2 : (idx == 2) ? 1 : 0;
    endfunction

    function automatic int unsigned stop_of(input int unsigned idx);
        return (idx == 3) ? 2 : 1;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned P = par_of(g);
        localparam int unsigned S = stop_of(g);
        uart_byte_tx_if u_if ();
        assign u_if.txStart = start_r[g];
        assign u_if.txData  = data_r[g];
        assign busy_w[g]    = u_if.txBusy;
        uart_byte_tx #(
            .CLK_FREQ  (1_000_000),
            .BAUD_RATE (100_000),
            .PARITY    (P),
            .STOP_BITS (S)
        ) u_dut (
            .clk        (clk),
            .uartTxRstN (rstN),
            .txIf       (u_if.slave),
            .tx         (tx_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ideal frame: bit j of the line, one entry per bit time.
    function automatic int frame_len(input int unsigned idx);
        int p;
        p = (par_of(idx) == 1 || par_of(idx) == 2) ? 1 : 0;
        return 10 + p + (int'(stop_of(idx)) - 1);
    endfunction

    function automatic logic [11:0] frame_bits(input int unsigned idx, input logic [7:0] d);
        logic [11:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = d[i];
        if (par_of(idx) == 1) f[9] = ~(^d);
        else if (par_of(idx) == 2) f[9] = ^d;
        return f;
    endfunction

    // Entered just after a negedge with the DUT idle. Requests byte d, then
    // samples every cycle of the frame plus the following idle cycle.
    // hold keeps txStart high; inj_at >= 0 pulses a 0x55 request mid-frame.
    task automatic run_frame(input int unsigned idx, input logic [7:0] d,
                             input bit hold, input int inj_at);
        int          nb;
        logic [11:0] f;
        int          waveErr;
        int          busyCnt;
        nb      = frame_len(idx);
        f       = frame_bits(idx, d);
        waveErr = 0;
        busyCnt = 0;
        check_eq("pre_busy", 32'(busy_w[idx]), 32'd0);
        start_r[idx] = 1'b1;
        data_r[idx]  = d;
        for (int j = 0; j < nb * int'(DIV); j++) begin
            @(negedge clk);
            if (busy_w[idx]) busyCnt++;
            if (tx_w[idx] !== f[j / int'(DIV)]) waveErr++;
            if (j % int'(DIV) == int'(DIV) / 2)
                check_eq($sformatf("bit%0d_%0d", idx, j / int'(DIV)),
                         32'(tx_w[idx]), 32'(f[j / int'(DIV)]));
            if (j == 0) begin
                check_eq("busy_rise", 32'(busy_w[idx]), 32'd1);
                check_eq("start_edge", 32'(tx_w[idx]), 32'd0);
                if (!hold) start_r[idx] = 1'b0;
                data_r[idx] = 8'($urandom);
            end
            if (j == inj_at) begin
                start_r[idx] = 1'b1;
                data_r[idx]  = 8'h55;
            end
            if (j == inj_at + 1) start_r[idx] = 1'b0;
        end
        check_eq($sformatf("wave%0d", idx), 32'(waveErr), 32'd0);
        check_eq($sformatf("busy_len%0d", idx), 32'(busyCnt), 32'(nb * int'(DIV)));
        @(negedge clk);
        check_eq("busy_fall", 32'(busy_w[idx]), 32'd0);
        check_eq("idle_tx", 32'(tx_w[idx]), 32'd1);
    endtask

    initial begin
        int idleErr;
        checks  = 0;
        errors  = 0;
        rstN    = 1'b0;
        start_r = '0;
        for (int i = 0; i < 4; i++) data_r[i] = '0;

        repeat (3) @(negedge clk);
        check_eq("rst_tx", 32'(tx_w), 32'hF);
        check_eq("rst_busy", 32'(busy_w), 32'h0);
        rstN = 1'b1;

        idleErr = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_w !== 4'hF || busy_w !== 4'h0) idleErr++;
        end
        check_eq("idle50", 32'(idleErr), 32'd0);

        run_frame(0, 8'h41, 1'b0, -1);
        run_frame(1, 8'h41, 1'b0, -1);
        run_frame(2, 8'h41, 1'b0, -1);

        // Back-to-back with txStart held: second frame starts from the idle cycle.
        run_frame(3, 8'hFF, 1'b1, -1);
        run_frame(3, 8'hFF, 1'b0, -1);

        // Request while busy must be neither honoured nor queued.
        run_frame(0, 8'h00, 1'b0, 29);
        idleErr = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy_w[0] !== 1'b0 || tx_w[0] !== 1'b1) idleErr++;
        end
        check_eq("no_queue", 32'(idleErr), 32'd0);

        // Reset in the middle of data bit 3 of 0xA5.
        start_r[0] = 1'b1;
        data_r[0]  = 8'hA5;
        for (int j = 0; j <= 43; j++) begin
            @(negedge clk);
            if (j == 0) start_r[0] = 1'b0;
        end
        check_eq("pre_rst_bit3", 32'(tx_w[0]), 32'(1'b0));
        check_eq("pre_rst_busy", 32'(busy_w[0]), 32'd1);
        #1 rstN = 1'b0;
        #1;
        check_eq("async_rst_tx", 32'(tx_w[0]), 32'd1);
        check_eq("async_rst_busy", 32'(busy_w[0]), 32'd0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        repeat (3) @(negedge clk);
        run_frame(0, 8'h3C, 1'b0, -1);

        // Random bytes on random channels with random idle gaps.
        for (int n = 0; n < 12; n++) begin
            int unsigned idx;
            idx = $urandom_range(0, 3);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_frame(idx, 8'($urandom), 1'b0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_byte_tx.md
# uart_byte_tx

Byte-level 8-bit UART serializer that drives the board TX pin. It sits directly downstream of the display/prompt formatting stage, which hands it one ASCII byte at a time over a txStart/txBusy handshake. Each accepted byte goes out as one asynchronous frame: start bit, 8 data bits LSB-first, optional parity, then 1 or 2 stop bits.

## Interface
- CLK_FREQ, 100_000_000: clk frequency in Hz.
- BAUD_RATE, 115200: line rate in bit/s. BAUD_DIV = CLK_FREQ / BAUD_RATE (integer division; 868 at defaults). BAUD_DIV ≥ 2 is required.
- PARITY, 0: 0 = none, 1 = odd, 2 = even. Value 3 is treated as none.
- STOP_BITS, 1: 1 or 2. Any other value is treated as 1.

Ports:
- clk  in  1  system clock.
- uartTxRstN  in  1  reset, asynchronous, active-low; clock clk.
- txStart  in  1  level request. Sampled only while idle.
- txData  in  8  byte to send. Sampled in the same cycle txStart is accepted.
- tx  out  1  serial line. Idles high.
- txBusy  out  1  high while a frame is in progress.

## Operation
- Reset values: tx = 1, txBusy = 0, FSM = IDLE, all counters = 0, shift register = 0. Reset takes effect immediately when asserted, even mid-frame; the line returns high.
- Frame-bit counter values:
  - P = 1 if PARITY is 1 or 2, otherwise 0.
  - S = STOP_BITS (after clamping).
  - Frame length in bits: NB = 10 + P + (S − 1).
- Parity bit:
  - Even: XOR of the 8 data bits.
  - Odd: inverse of that XOR.
- FSM states and transitions:
  - IDLE: tx = 1. If txStart = 1, latch txData into the shift register, clear the baud and bit counters, go to START.
  - START: tx = 0 for one bit time, then go to DATA.
  - DATA: tx = shreg[0]. At each bit-time end, shift right and increment the bit index. After 8 bits, go to PARITY if P = 1, otherwise go to STOP.
  - PARITY: tx = parity bit for one bit time, then go to STOP.
  - STOP: tx = 1 for S bit times, then go to IDLE.
- One bit time is BAUD_DIV clocks. The baud counter runs 0..BAUD_DIV−1, and the bit-time end is the cycle where count = BAUD_DIV−1. Counter width is clog2(BAUD_DIV).
- txBusy = 1 in every state except IDLE. It is registered, not combinational.
- txData changes after acceptance are ignored; the byte is latched.
- Handshake: the upstream stage raises txStart, waits for txBusy = 1, drops txStart, then waits for txBusy = 0 before sending the next byte.
- If txStart is still high when the FSM reaches IDLE, a new frame starts. This is legal back-to-back operation.
- txStart while busy is ignored and is not queued.

## Timing
- Let k be the acceptance cycle (IDLE with txStart = 1).
- Cycle k+1: txBusy = 1 and tx = 0 (start of the start bit).
- Data bit i (i = 0..7) occupies cycles k+1+(i+1)·BAUD_DIV through k+(i+2)·BAUD_DIV.
- txBusy is high for exactly NB·BAUD_DIV cycles. It falls at cycle k+1+NB·BAUD_DIV.
- Minimum idle gap between back-to-back frames is 1 clock: the IDLE cycle, with tx = 1.
- Output latency from txStart to the falling edge on tx is 1 clock.

## Structure
- Shared package `uart_pkg` holds:
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP).
  - Parity mode constants (PAR_NONE, PAR_ODD, PAR_EVEN).
  - A clog2 helper function.
- Natural sub-module: `uart_baud_tick`.
  - Counter 0..BAUD_DIV−1 that emits a one-cycle tick at BAUD_DIV−1.
  - Its clear input is driven on frame acceptance.
- The FSM, shift register, bit counter, and parity accumulator stay in uart_byte_tx.

## Test plan
All scenarios use CLK_FREQ = 1_000_000 and BAUD_RATE = 100_000, so BAUD_DIV = 10.
- Reset, then 50 idle cycles → tx = 1 and txBusy = 0 throughout. No change while txStart = 0.
- Send 0x41, PARITY = 0, STOP_BITS = 1 → tx sampled at bit centres is 0,1,0,0,0,0,0,1,0,1. txBusy is high for exactly 100 cycles, starting the cycle after acceptance.
- Send 0x41 with PARITY = 2 (even), then again with PARITY = 1 (odd) → parity bit is 0 for even and 1 for odd. Frame is 110 cycles.
- Send 0xFF, STOP_BITS = 2, with txStart held high continuously → two back-to-back frames of 110 cycles each, separated by exactly 1 idle cycle with tx = 1.
- Pulse txStart with 0x55 at cycle 30 of a 0x00 frame → the 0x55 request is ignored and the 0x00 frame is unaltered.
- Assert uartTxRstN low during data bit 3 of 0xA5 → in the same cycle, tx = 1 and txBusy = 0. After release, a 0x3C request transmits correctly.
